systolic_input_packer: RTL and testbench
========================================

Name: systolic_input_packer

Overview:
- Upstream feeder for the systolic array controller.
- Accepts a serial element stream tagged as activation (x) or weight (w) and assembles each lane's elements into size-wide vectors. One vector feeds one entry into every per-row FIFO.
- Presents completed vectors on two independent val/rdy send interfaces.
- Asserts a done flag once a full matrix (depth vectors per lane) has been delivered.

Parameters:
size, 16, number of array rows; elements per vector.
width, 16, bits per element.
depth, 16, vectors per lane per matrix (matrix columns streamed).

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
recv_msg  input  width  incoming element
recv_sel  input  1  0 = x lane, 1 = w lane
recv_val  input  1  element valid
recv_rdy  output  1  block can accept the element on the selected lane
x_send_msg  output  size*width  x vector; element k at bits [k*width +: width]
x_send_val  output  1  x vector valid
x_send_rdy  input  1  downstream accepts x vector
w_send_msg  output  size*width  w vector; same packing as x
w_send_val  output  1  w vector valid
w_send_rdy  input  1  downstream accepts w vector
restart  input  1  single-cycle pulse; clears done and vector counts
done  output  1  sticky; depth vectors sent on both lanes
recv_last  input  1  present only with SYSTOLIC_PACKER_ZPAD_EN

Behaviour:
- Reset values (async on rst):
  - all element counters = 0, vector counters = 0, full flags = 0
  - send_msg = 0, send_val = 0, done = 0, recv_rdy = 0 while rst is high
  - reset mid-vector discards partial data.
- Lane assemblers: x and w are independent. Each lane has:
  - elem_cnt, 0..size-1
  - holding register of size*width bits
  - full flag
  - vec_cnt, 0..depth
- Accept rule:
  - recv_rdy = !full[recv_sel] && !lane_done[recv_sel] && !done.
  - recv_rdy is combinational from registered state and recv_sel only; it never depends on either send_rdy.
  - On recv_val && recv_rdy, recv_msg is written into slot elem_cnt of the selected lane, and elem_cnt increments.
- Vector completion:
  - An accept at elem_cnt == size-1 wraps elem_cnt to 0 and sets full on the next edge.
  - send_val = full, registered; the first vector appears 1 cycle after its last element.
- Send handshake:
  - On send_val && send_rdy, full clears and vec_cnt increments.
  - send_msg holds stable while send_val && !send_rdy.
  - send_val never depends combinationally on send_rdy. This is required because the downstream rdy follows val.
- Throughput: one element per cycle per lane, minus a 1-cycle minimum bubble after each vector. A lane stalls while its vector is unsent. The other lane keeps accepting.
- Lane done:
  - vec_cnt == depth sets lane_done; that lane refuses further elements.
  - done = lane_done_x && lane_done_w, registered. It asserts the cycle after the second lane's final send.
- restart:
  - Clears vec_cnt, lane_done and done.
  - Does not clear a pending full vector or elem_cnt.
  - If restart coincides with a final send, restart wins: counts = 0, done stays 0.
- Width rules:
  - elem_cnt is $clog2(size) bits; vec_cnt is $clog2(depth+1) bits.
  - Data passes unmodified, with no arithmetic.

Optional Feature:
- Macro: SYSTOLIC_PACKER_ZPAD_EN.
- Enabled:
  - The recv_last port exists.
  - An accepted element with recv_last = 1 completes the vector immediately. Slots above elem_cnt are zero-filled, full is set, and elem_cnt returns to 0.
  - recv_last at slot size-1 behaves as a normal completion.
- Disabled:
  - The port is absent.
  - Vectors complete only at size elements.

Decomposition:
- Package systolic_pkg holds:
  - lane-select constants SYS_LANE_X = 1'b0, SYS_LANE_W = 1'b1
  - a typedef for the element counter width helper
- Sub-module systolic_lane_packer (one lane: counter, holding register, full flag, vec_cnt, send handshake), instantiated twice.
- Top level contains accept steering, done and restart.

Test Plan (size=4, width=8, depth=2):
- Stream x elements 0x11, 0x22, 0x33, 0x44 with x_send_rdy=1 → x_send_val high 1 cycle after 0x44 with x_send_msg = 0x44332211; w lane untouched.
- Fill an x vector with x_send_rdy=0 and offer a 5th x element → recv_rdy=0 and x_send_msg stable; raise rdy → vector sent, 5th element accepted the next cycle.
- Interleave x and w elements alternately for 2 vectors each → both lanes deliver 2 correct vectors; done=1 one cycle after the last send; further recv_rdy=0.
- Assert rst asynchronously mid-vector (elem_cnt=2) → outputs zero immediately; the next 4 elements form a fresh vector.
- Pulse restart after done → done=0; a third vector per lane is accepted and delivered.
- ZPAD build: x elements 0xAA, 0xBB with recv_last on 0xBB → x_send_msg = 0x0000BBAA.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared lane-select constants and counter-width helper for the systolic input packer.
package systolic_pkg;

  localparam logic SYS_LANE_X = 1'b0;
  localparam logic SYS_LANE_W = 1'b1;

  typedef int unsigned sys_cnt_width_t;

  // Bits needed to index n distinct values; never less than one so tiny configs still elaborate.
  function automatic sys_cnt_width_t sys_cnt_bits(input sys_cnt_width_t n);
    sys_cnt_width_t bits;
    bits = 32'd1;
    if (n > 32'd2) begin
      bits = $clog2(n);
    end else begin
      bits = 32'd1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/systolic_lane_packer.sv
// One lane of the input packer: element slot counter, vector holding register,
// full flag with val/rdy send handshake, and the per-matrix vector count.
module systolic_lane_packer
  import systolic_pkg::*;
#(
  parameter int size  = 16,
  parameter int width = 16,
  parameter int depth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  accept,
  input  logic [width-1:0]      msg,
  input  logic                  last,
  output logic                  full,
  output logic                  lane_done,
  output logic                  lane_done_next,
  output logic [size*width-1:0] send_msg,
  output logic                  send_val,
  input  logic                  send_rdy
);

  localparam int EW = int'(sys_cnt_bits(sys_cnt_width_t'(size)));
  localparam int VW = int'(sys_cnt_bits(sys_cnt_width_t'(depth + 1)));
  localparam logic [EW-1:0] LAST_SLOT = EW'(size - 1);
  localparam logic [VW-1:0] VEC_MAX   = VW'(depth);

  logic [EW-1:0]         elem_cnt_r;
  logic [VW-1:0]         vec_cnt_r;
  logic [VW-1:0]         vec_cnt_s;
  logic [size*width-1:0] hold_r;
  logic                  full_r;
  logic                  send_s;
  logic                  complete_s;

  // Handshake decode and next vector count; restart beats a coincident send.
  always_comb begin
    send_s     = full_r && send_rdy;
    complete_s = accept && ((elem_cnt_r == LAST_SLOT) || last);
    vec_cnt_s  = vec_cnt_r;
    if (restart) begin
      vec_cnt_s = {VW{1'b0}};
    end else if (send_s && (vec_cnt_r != VEC_MAX)) begin
      vec_cnt_s = vec_cnt_r + VW'(1);
    end else begin
      vec_cnt_s = vec_cnt_r;
    end
  end

  // Slot writes, optional zero-fill of the unused upper slots, full flag and vector count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt_r <= {EW{1'b0}};
      vec_cnt_r  <= {VW{1'b0}};
      hold_r     <= {(size*width){1'b0}};
      full_r     <= 1'b0;
    end else begin
      vec_cnt_r <= vec_cnt_s;
      if (accept) begin
        elem_cnt_r <= complete_s ? {EW{1'b0}} : (elem_cnt_r + EW'(1));
        for (int k = 0; k < size; k++) begin
          if (EW'(k) == elem_cnt_r) begin
            hold_r[k*width +: width] <= msg;
          end else if (last && (EW'(k) > elem_cnt_r)) begin
            hold_r[k*width +: width] <= {width{1'b0}};
          end else begin
            hold_r[k*width +: width] <= hold_r[k*width +: width];
          end
        end
      end else begin
        elem_cnt_r <= elem_cnt_r;
      end
      if (complete_s) begin
        full_r <= 1'b1;
      end else if (send_s) begin
        full_r <= 1'b0;
      end else begin
        full_r <= full_r;
      end
    end
  end

  assign full           = full_r;
  assign send_val       = full_r;
  assign send_msg       = hold_r;
  assign lane_done      = (vec_cnt_r == VEC_MAX);
  assign lane_done_next = (vec_cnt_s == VEC_MAX);

endmodule

// File: rtl/systolic_input_packer.sv
// Packs a tagged serial element stream into x/w vectors for the systolic array.
// Optional SYSTOLIC_PACKER_ZPAD_EN adds recv_last for zero-padded short vectors.
module systolic_input_packer
  import systolic_pkg::*;
#(
  parameter int size  = 16,
  parameter int width = 16,
  parameter int depth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [width-1:0]      recv_msg,
  input  logic                  recv_sel,
  input  logic                  recv_val,
  output logic                  recv_rdy,
`ifdef SYSTOLIC_PACKER_ZPAD_EN
  input  logic                  recv_last,
`endif
  output logic [size*width-1:0] x_send_msg,
  output logic                  x_send_val,
  input  logic                  x_send_rdy,
  output logic [size*width-1:0] w_send_msg,
  output logic                  w_send_val,
  input  logic                  w_send_rdy,
  input  logic                  restart,
  output logic                  done
);

  logic last_s;
  logic x_full_s, w_full_s;
  logic x_lane_done_s, w_lane_done_s;
  logic x_done_next_s, w_done_next_s;
  logic sel_full_s, sel_done_s;
  logic accept_x_s, accept_w_s;
  logic done_r;

`ifdef SYSTOLIC_PACKER_ZPAD_EN
  assign last_s = recv_last;
`else
  assign last_s = 1'b0;
`endif

  // Steer the accept to the selected lane; ready never looks at either send_rdy.
  always_comb begin
    sel_full_s = x_full_s;
    sel_done_s = x_lane_done_s;
    if (recv_sel == SYS_LANE_W) begin
      sel_full_s = w_full_s;
      sel_done_s = w_lane_done_s;
    end else begin
      sel_full_s = x_full_s;
      sel_done_s = x_lane_done_s;
    end
    recv_rdy   = !rst && !sel_full_s && !sel_done_s && !done_r;
    accept_x_s = recv_val && recv_rdy && (recv_sel == SYS_LANE_X);
    accept_w_s = recv_val && recv_rdy && (recv_sel == SYS_LANE_W);
  end

  systolic_lane_packer #(.size(size), .width(width), .depth(depth)) u_x_lane (
    .clk            (clk),
    .rst            (rst),
    .restart        (restart),
    .accept         (accept_x_s),
    .msg            (recv_msg),
    .last           (last_s),
    .full           (x_full_s),
    .lane_done      (x_lane_done_s),
    .lane_done_next (x_done_next_s),
    .send_msg       (x_send_msg),
    .send_val       (x_send_val),
    .send_rdy       (x_send_rdy)
  );

  systolic_lane_packer #(.size(size), .width(width), .depth(depth)) u_w_lane (
    .clk            (clk),
    .rst            (rst),
    .restart        (restart),
    .accept         (accept_w_s),
    .msg            (recv_msg),
    .last           (last_s),
    .full           (w_full_s),
    .lane_done      (w_lane_done_s),
    .lane_done_next (w_done_next_s),
    .send_msg       (w_send_msg),
    .send_val       (w_send_val),
    .send_rdy       (w_send_rdy)
  );

  // Done tracks the lanes' next counts so it rises right after the second lane's final send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= x_done_next_s && w_done_next_s;
    end
  end

  assign done = done_r;

endmodule

// File: tb/tb_systolic_input_packer.sv
// Randomized self-checking bench for systolic_input_packer (size=4, width=8, depth=2)
// against a queue-style model of accepted elements, pending vectors and send counts.
module tb_systolic_input_packer;

  localparam int SIZE  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  recv_msg;
  logic        recv_sel;
  logic        recv_val;
  logic        recv_rdy;
  logic        recv_last;
  logic [31:0] x_send_msg;
  logic        x_send_val;
  logic        x_send_rdy;
  logic [31:0] w_send_msg;
  logic        w_send_val;
  logic        w_send_rdy;
  logic        restart;
  logic        done;

  int checks;
  int failures;
  int last_wait;

  systolic_input_packer #(.size(SIZE), .width(WIDTH), .depth(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .recv_msg   (recv_msg),
    .recv_sel   (recv_sel),
    .recv_val   (recv_val),
    .recv_rdy   (recv_rdy),
`ifdef SYSTOLIC_PACKER_ZPAD_EN
    .recv_last  (recv_last),
`endif
    .x_send_msg (x_send_msg),
    .x_send_val (x_send_val),
    .x_send_rdy (x_send_rdy),
    .w_send_msg (w_send_msg),
    .w_send_val (w_send_val),
    .w_send_rdy (w_send_rdy),
    .restart    (restart),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: elements collected so far, a completed-but-unsent vector, vectors sent per matrix.
  logic [7:0]  partv [2][SIZE];
  int          pcnt  [2];
  bit          pend  [2];
  logic [31:0] pvec  [2];
  int          sent  [2];
  bit          mdone;
  bit          mr    [2];
  bit          ms    [2];
  int          ml;

  function automatic bit m_rdy(input int l);
    return !pend[l] && (sent[l] != DEPTH) && !mdone;
  endfunction

  function automatic logic [31:0] pack(input int l);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < pcnt[l]; i++) v[i*8 +: 8] = partv[l][i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        pend[l] = 1'b0;
        pcnt[l] = 0;
        sent[l] = 0;
        pvec[l] = 32'h0;
      end
      mdone = 1'b0;
    end else begin
      mr[0] = m_rdy(0);
      mr[1] = m_rdy(1);
      ms[0] = x_send_rdy;
      ms[1] = w_send_rdy;
      for (int l = 0; l < 2; l++) begin
        if (pend[l] && ms[l]) begin
          pend[l] = 1'b0;
          sent[l]++;
        end
      end
      ml = recv_sel ? 1 : 0;
      if (recv_val && mr[ml]) begin
        partv[ml][pcnt[ml]] = recv_msg;
        pcnt[ml]++;
        if (pcnt[ml] == SIZE || recv_last) begin
          pvec[ml] = pack(ml);
          pend[ml] = 1'b1;
          pcnt[ml] = 0;
        end
      end
      if (restart) begin
        sent[0] = 0;
        sent[1] = 0;
        mdone   = 1'b0;
      end else begin
        mdone = (sent[0] == DEPTH) && (sent[1] == DEPTH);
      end
    end
  end

  // Every cycle out of reset: compare outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("recv_rdy", {31'h0, recv_rdy}, {31'h0, m_rdy(recv_sel ? 1 : 0)});
      chk("x_send_val", {31'h0, x_send_val}, {31'h0, pend[0]});
      if (pend[0]) chk("x_send_msg", x_send_msg, pvec[0]);
      chk("w_send_val", {31'h0, w_send_val}, {31'h0, pend[1]});
      if (pend[1]) chk("w_send_msg", w_send_msg, pvec[1]);
      chk("done", {31'h0, done}, {31'h0, mdone});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic sel, input logic [7:0] m, input logic lst);
    int n;
    bit got;
    recv_val  = 1'b1;
    recv_sel  = sel;
    recv_msg  = m;
    recv_last = lst;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = m_rdy(sel ? 1 : 0);
      @(posedge clk);
      #1;
      n++;
    end
    recv_val  = 1'b0;
    recv_last = 1'b0;
    last_wait = n;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL put_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  initial begin
    checks = 0; failures = 0; last_wait = 0;
    rst = 1'b1; recv_val = 1'b0; recv_sel = 1'b0; recv_msg = 8'h0; recv_last = 1'b0;
    x_send_rdy = 1'b1; w_send_rdy = 1'b1; restart = 1'b0;
    #1;
    chk("reset_recv_rdy", {31'h0, recv_rdy}, 32'h0);
    chk("reset_x_val", {31'h0, x_send_val}, 32'h0);
    chk("reset_x_msg", x_send_msg, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Basic x vector, w lane untouched.
    put(1'b0, 8'h11, 1'b0); put(1'b0, 8'h22, 1'b0); put(1'b0, 8'h33, 1'b0); put(1'b0, 8'h44, 1'b0);
    chk("t1_x_val", {31'h0, x_send_val}, 32'h1);
    chk("t1_x_msg", x_send_msg, 32'h44332211);
    chk("t1_w_val", {31'h0, w_send_val}, 32'h0);
    tick();
    restart = 1'b1; tick(); restart = 1'b0;

    // Backpressure: a 5th element waits until the held vector leaves.
    x_send_rdy = 1'b0;
    put(1'b0, 8'hA1, 1'b0); put(1'b0, 8'hA2, 1'b0); put(1'b0, 8'hA3, 1'b0); put(1'b0, 8'hA4, 1'b0);
    recv_val = 1'b1; recv_sel = 1'b0; recv_msg = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall_rdy", {31'h0, recv_rdy}, 32'h0);
      chk("t2_stall_msg", x_send_msg, 32'hA4A3A2A1);
      tick();
    end
    x_send_rdy = 1'b1;
    put(1'b0, 8'hA5, 1'b0);
    chk("t2_accept_latency", last_wait, 32'd2);
    put(1'b0, 8'hA6, 1'b0);

    // Asynchronous reset with two elements collected.
    #2 rst = 1'b1;
    #1;
    chk("t3_rst_x_msg", x_send_msg, 32'h0);
    chk("t3_rst_x_val", {31'h0, x_send_val}, 32'h0);
    chk("t3_rst_rdy", {31'h0, recv_rdy}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    put(1'b0, 8'hC1, 1'b0); put(1'b0, 8'hC2, 1'b0); put(1'b0, 8'hC3, 1'b0); put(1'b0, 8'hC4, 1'b0);
    chk("t3_fresh_msg", x_send_msg, 32'hC4C3C2C1);
    tick();
    restart = 1'b1; tick(); restart = 1'b0;

    // Interleaved x/w for a full matrix.
    for (int v = 0; v < DEPTH; v++) begin
      for (int i = 0; i < SIZE; i++) begin
        put(1'b0, 8'($urandom), 1'b0);
        put(1'b1, 8'($urandom), 1'b0);
      end
    end
    chk("t4_w_val", {31'h0, w_send_val}, 32'h1);
    chk("t4_done_early", {31'h0, done}, 32'h0);
    tick();
    chk("t4_done", {31'h0, done}, 32'h1);
    recv_sel = 1'b0; #1;
    chk("t4_rdy_x_after_done", {31'h0, recv_rdy}, 32'h0);
    recv_sel = 1'b1; #1;
    chk("t4_rdy_w_after_done", {31'h0, recv_rdy}, 32'h0);
    tick();

    // Restart after done, then a third vector per lane.
    restart = 1'b1; tick(); restart = 1'b0;
    chk("t5_done_cleared", {31'h0, done}, 32'h0);
    chk("t5_rdy_again", {31'h0, recv_rdy}, 32'h1);
    for (int i = 0; i < SIZE; i++) put(1'b0, 8'($urandom), 1'b0);
    chk("t5_x_val", {31'h0, x_send_val}, 32'h1);
    for (int i = 0; i < SIZE; i++) put(1'b1, 8'($urandom), 1'b0);
    chk("t5_w_val", {31'h0, w_send_val}, 32'h1);
    tick(); tick();

`ifdef SYSTOLIC_PACKER_ZPAD_EN
    put(1'b0, 8'hAA, 1'b0);
    put(1'b0, 8'hBB, 1'b1);
    chk("t6_zpad_val", {31'h0, x_send_val}, 32'h1);
    chk("t6_zpad_msg", x_send_msg, 32'h0000BBAA);
    tick();
`endif

    // Random traffic with random backpressure and occasional restart.
    for (int c = 0; c < 3000; c++) begin
      recv_val   = 1'($urandom_range(0, 1));
      recv_sel   = 1'($urandom_range(0, 1));
      recv_msg   = 8'($urandom);
      x_send_rdy = ($urandom_range(0, 3) != 0);
      w_send_rdy = ($urandom_range(0, 3) != 0);
      restart    = ($urandom_range(0, 40) == 0);
`ifdef SYSTOLIC_PACKER_ZPAD_EN
      recv_last  = ($urandom_range(0, 5) == 0);
`endif
      tick();
    end
    recv_val = 1'b0; restart = 1'b0; recv_last = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
